// File: rtl/vga_pixel_fifo_pkg.sv
// Shared VGA timing constants and FIFO types, common to vga_driver and vga_pixel_fifo.
package vga_pixel_fifo_pkg;
  localparam int          H_DISP           = 640;
  localparam int          V_DISP           = 480;
  localparam logic [15:0] UF_COLOR_DEFAULT = 16'hF800;
  localparam int          LEVEL_W          = 11;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2
  } fifo_state_t;

  // Source of the next pixel, registered next to the RAM read data
  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_UF   = 2'd2
  } pix_sel_t;
endpackage

// File: rtl/vga_fifo_ram.sv
// Simple dual-port DEPTH x 16 pixel store; synchronous write and registered read.
module vga_fifo_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              vga_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_din,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_dout
);
  logic [15:0] mem [DEPTH];

  always_ff @(posedge vga_clk) begin
    if (wr_en) mem[wr_addr] <= wr_din;
    if (rd_en) rd_dout <= mem[rd_addr];
  end
endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO between the frame source and the VGA driver; refills at each field
// start and substitutes UF_COLOR whenever the driver asks for a pixel it cannot get.
module vga_pixel_fifo
  import vga_pixel_fifo_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          FILL_THRESH = H_DISP,
  parameter logic [15:0] UF_COLOR    = UF_COLOR_DEFAULT
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic [15:0]        wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic               vga_vs,
  input  logic               data_req,
  output logic [15:0]        pixel_data,
  output logic [LEVEL_W-1:0] fifo_level,
  output logic               frame_ready,
  output logic               underflow,
  input  logic               underflow_clr
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] THRESH = (ADDR_W + 1)'(FILL_THRESH);

  fifo_state_t     state, state_nxt;
  pix_sel_t        sel_q;
  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_q;
  logic            vs_d, vs_fall, rst_done;
  logic            full, empty, push, pop, uf_req;
  logic [15:0]     ram_dout;

  assign vs_fall  = vs_d & ~vga_vs;
  assign full     = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign empty    = (wr_ptr == rd_ptr);
  // rst_done holds wr_ready low until the first edge after reset release
  assign wr_ready = rst_done & ~full & (state != ST_FLUSH);
  assign push     = wr_valid & wr_ready;
  assign pop      = data_req & (state == ST_RUN) & ~empty;
  assign uf_req   = data_req & ~pop;

  assign frame_ready = (state == ST_RUN);
  assign fifo_level  = LEVEL_W'(level_q);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_FILL;
      vs_d     <= 1'b1;
      rst_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      vs_d     <= vga_vs;
      rst_done <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (vs_fall) begin
      state_nxt = ST_FLUSH;
    end else begin
      case (state)
        ST_FLUSH: state_nxt = ST_FILL;
        ST_FILL:  if (level_q >= THRESH) state_nxt = ST_RUN;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    wr_ptr_nxt = wr_ptr + {{ADDR_W{1'b0}}, push};
    rd_ptr_nxt = rd_ptr + {{ADDR_W{1'b0}}, pop};
  end

  // Level is registered from the next pointers so it always matches them
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (state == ST_FLUSH) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      level_q <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel_q     <= SEL_ZERO;
      underflow <= 1'b0;
    end else begin
      if (pop)         sel_q <= SEL_RAM;
      else if (uf_req) sel_q <= SEL_UF;
      else             sel_q <= SEL_ZERO;
      if (uf_req)             underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;
    end
  end

  always_comb begin
    pixel_data = 16'd0;
    case (sel_q)
      SEL_RAM: pixel_data = ram_dout;
      SEL_UF:  pixel_data = UF_COLOR;
      default: pixel_data = 16'd0;
    endcase
  end

  vga_fifo_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .vga_clk (vga_clk),
    .wr_en   (push),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_din  (wr_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_dout (ram_dout)
  );
endmodule

// File: doc/vga_pixel_fifo.md
VGA_PIXEL_FIFO -- requirements
Module: vga_pixel_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, FIFO depth in RGB565 words (power of two).
REQ-002 SHALL have parameter FILL_THRESH, default 640, level required to leave FILL.
REQ-003 SHALL have parameter UF_COLOR, default 16'hF800, colour driven on underflow.
REQ-004 SHALL have port vga_clk  in  1  pixel clock, sole clock.
REQ-005 SHALL have port sys_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port wr_data  in  16  upstream RGB565 pixel.
REQ-007 SHALL have port wr_valid  in  1  wr_data valid.
REQ-008 SHALL have port wr_ready  out  1  FIFO accepts wr_data this cycle.
REQ-009 SHALL have port vga_vs  in  1  field sync from the VGA driver, active low.
REQ-010 SHALL have port data_req  in  1  pixel request from the VGA driver.
REQ-011 SHALL have port pixel_data  out  16  pixel to the VGA driver.
REQ-012 SHALL have port fifo_level  out  11  current occupancy, 0..DEPTH.
REQ-013 SHALL have port frame_ready  out  1  high while state is RUN.
REQ-014 SHALL have port underflow  out  1  sticky underflow flag.
REQ-015 SHALL have port underflow_clr  in  1  clears underflow.

Function
REQ-016 SHALL push wr_data when wr_valid and wr_ready are both high; wr_ready = !full and state != FLUSH.
REQ-017 SHALL implement states FLUSH, FILL, RUN; FLUSH lasts exactly one cycle then goes to FILL.
REQ-018 SHALL go from FILL to RUN the cycle after fifo_level >= FILL_THRESH.
REQ-019 SHALL detect a vga_vs falling edge (registered vs_d = 1, vga_vs = 0) from any state and enter FLUSH next cycle.
REQ-020 SHALL, in FLUSH, zero the read and write pointers and fifo_level; pushes and pops are ignored.
REQ-021 SHALL pop one word per data_req cycle in RUN when not empty.
REQ-022 SHALL present pixel_data registered, one cycle after the data_req cycle: the popped word; UF_COLOR if that data_req was an underflow; 16'd0 if data_req was low.
REQ-023 SHALL treat data_req in FILL or FLUSH, or in RUN with empty FIFO, as underflow: no pop, pointers unchanged, underflow set.
REQ-024 SHALL keep fifo_level unchanged on a simultaneous push and pop; pop from empty with push counts only the push.
REQ-025 SHALL give set priority over underflow_clr in the same cycle.
REQ-026 SHALL use ADDR_W+1-bit pointers (wrap bit): full when addresses are equal and wrap bits differ, empty when pointers are fully equal.
REQ-027 SHALL derive fifo_level = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)), registered.

Reset
REQ-028 SHALL on sys_rst_n low asynchronously set: state FILL, pointers 0, fifo_level 0, pixel_data 0, underflow 0, frame_ready 0, vs_d 1, wr_ready 0.
REQ-029 SHALL raise wr_ready the first cycle after reset release; RAM contents need no reset.
REQ-030 SHALL, on reset mid-frame, discard all buffered data; there is no recovery of partial lines.

Structure
REQ-031 SHALL take shared VGA timing constants (H_DISP = 640, V_DISP = 480) and UF_COLOR default from the team VGA defines include shared with vga_driver.
REQ-032 SHALL instantiate one sub-module vga_fifo_ram: simple dual-port DEPTH x 16, synchronous write and synchronous read, inferable as block RAM.
REQ-033 SHALL keep the underflow select registered alongside the RAM read register so the pixel_data mux has no combinational path from data_req.

Verification
REQ-034 Reset, push 640 words 0..639 -> frame_ready rises the cycle after level = 640; wr_ready high throughout.
REQ-035 RUN, data_req high for 640 cycles -> pixel_data = 0..639 in order, each one cycle after its request; level returns to 0; underflow stays 0.
REQ-036 Push 1024 words without popping -> wr_ready low at level 1024; the 1025th word is not written; first pop then returns word 0.
REQ-037 RUN with 2 words, data_req for 3 cycles -> pixel_data = w0, w1, 16'hF800; underflow set; underflow_clr pulse clears it; simultaneous clear and underflow leaves it set.
REQ-038 vga_vs falls with 300 words buffered -> one FLUSH cycle with wr_ready 0, level 0, state FILL, frame_ready 0.
REQ-039 Continuous push with simultaneous data_req in RUN at level 700 -> level stays 700 and output order is preserved.
